// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter:
//   FSM state encoding, well-known PS/2 command/response bytes,
//   bit-counter constants and the parity helper.
//
// Configuration macro consumed by ps2_host_tx: PS2_TX_RETRY_EN

package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    localparam int         PS2_BIT_CNT_W    = 4;
    // Falling edges already seen when the ACK edge (fe#11) arrives.
    localparam logic [3:0] PS2_ACK_FE_CNT   = 4'd10;
    // Terminal value of the bit counter once the ACK has been sampled.
    localparam logic [3:0] PS2_BIT_CNT_END  = 4'd11;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
//   Two-flop synchroniser for the PS/2 clock and data pins plus a
//   one-cycle pulse on each falling edge of the synchronised clock.
//   Intended to be shared with the keyboard receive path.
//
// Ports
//   clk          in   system clock
//   rstn         in   synchronous active-low reset
//   ps2_clk_in   in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in  in   raw PS/2 data pin (asynchronous)
//   clk_s        out  synchronised clock level
//   data_s       out  synchronised data level
//   clk_fe       out  1-cycle pulse: synchronised clock went 1 -> 0

module ps2_line_sync (
    input  logic clk,
    input  logic rstn,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fe
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            data_ff  <= {data_ff[0], ps2_data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
    assign clk_fe = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the device:
//   clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop,
//   then samples the device ACK. Both bus lines are driven as pull-low
//   enables only (open drain). Typical use: 0xED followed by an LED byte.
//
// Optional feature macro: PS2_TX_RETRY_EN
//   defined   : on ACK or timeout failure restart from INHIBIT with the
//               latched byte, up to MAX_RETRY times; the error pulse fires
//               only after the last attempt and busy stays high throughout.
//   undefined : the first failure pulses its error and returns to IDLE.
//
// Ports
//   clk                 in   system clock
//   rstn                in   synchronous active-low reset
//   tx_valid            in   command byte available
//   tx_data[7:0]        in   command byte
//   tx_ready            out  high only in IDLE; accept = tx_valid && tx_ready
//   ps2_clk_in          in   raw PS/2 clock pin level
//   ps2_data_in         in   raw PS/2 data pin level
//   ps2_clk_drive_low   out  1 = pull PS/2 clock low
//   ps2_data_drive_low  out  1 = pull PS/2 data low
//   busy                out  transfer in progress (any state but IDLE)
//   done                out  1-cycle pulse: byte sent and ACK received
//   ack_err             out  1-cycle pulse: ACK bit sampled high
//   timeout_err         out  1-cycle pulse: watchdog expired
//
// States
//   ST_IDLE      | lines released, waiting for tx_valid
//   ST_INHIBIT   | clock held low for the inhibit time
//   ST_RTS       | data held low, clock released, waiting for fe#1
//   ST_XFER      | fe#1..#10 shift data/parity/stop, fe#11 samples ACK
//   ST_WAIT_IDLE | waiting for both lines high before reporting

module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int INH_CYC  = (CLK_HZ / 1_000_000) * INHIBIT_US;
    localparam int WDT_CYC  = (CLK_HZ / 1_000) * TIMEOUT_MS;
    localparam int MAX_LOAD = ((INH_CYC > WDT_CYC) ? INH_CYC : WDT_CYC) - 1;
    localparam int TMR_W    = (MAX_LOAD < 2) ? 1 : $clog2(MAX_LOAD + 1);

    // Loads are cycles-1 so the terminal count (zero) is the last cycle.
    localparam logic [TMR_W-1:0] INH_LOAD = TMR_W'(INH_CYC - 1);
    localparam logic [TMR_W-1:0] WDT_LOAD = TMR_W'(WDT_CYC - 1);

    if (CLK_HZ < 1_000_000 || INHIBIT_US < 1 || TIMEOUT_MS < 1 || MAX_RETRY < 0) begin : g_bad_param
        $error("ps2_host_tx: CLK_HZ must be >= 1 MHz, times >= 1, MAX_RETRY >= 0");
    end

    logic clk_s;
    logic data_s;
    logic clk_fe;

    ps2_line_sync u_sync (
        .clk         (clk),
        .rstn        (rstn),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_s       (clk_s),
        .data_s      (data_s),
        .clk_fe      (clk_fe)
    );

    ps2_tx_state_e              state_q, state_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d, tmr_dec;
    logic [PS2_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [8:0]                 shift_q, shift_d;
    logic [7:0]                 byte_q, byte_d;
    logic                       par_q, par_d;
    logic                       data_low_q, data_low_d;
    logic                       ack_bad_q, ack_bad_d;
    logic                       done_q, done_d;
    logic                       ack_err_q, ack_err_d;
    logic                       timeout_q, timeout_d;
    logic                       fail;
    logic                       fail_timeout;

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0]         retry_q, retry_d;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            byte_q     <= '0;
            par_q      <= 1'b0;
            data_low_q <= 1'b0;
            ack_bad_q  <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            data_low_q <= data_low_d;
            ack_bad_q  <= ack_bad_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        par_d        = par_q;
        data_low_d   = data_low_q;
        ack_bad_d    = ack_bad_q;
        done_d       = 1'b0;
        ack_err_d    = 1'b0;
        timeout_d    = 1'b0;
        fail         = 1'b0;
        fail_timeout = 1'b0;
        // Saturating decrement: the timer parks at zero, never wraps.
        tmr_dec      = (tmr_q == '0) ? '0 : tmr_q - 1'b1;
`ifdef PS2_TX_RETRY_EN
        retry_d      = retry_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                data_low_d = 1'b0;
                if (tx_valid) begin
                    byte_d  = tx_data;
                    par_d   = ps2_odd_parity(tx_data);
                    tmr_d   = INH_LOAD;
                    state_d = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d = '0;
`endif
                end
            end

            ST_INHIBIT: begin
                if (tmr_q == '0) begin
                    state_d    = ST_RTS;
                    data_low_d = 1'b1;
                    tmr_d      = WDT_LOAD;
                    bit_cnt_d  = '0;
                    shift_d    = {par_q, byte_q};
                    ack_bad_d  = 1'b0;
                end else begin
                    tmr_d = tmr_dec;
                end
            end

            ST_RTS: begin
                if (clk_fe) begin
                    tmr_d      = WDT_LOAD;
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b1, shift_q[8:1]};
                    bit_cnt_d  = 4'd1;
                    state_d    = ST_XFER;
                end else if (tmr_q == '0) begin
                    fail         = 1'b1;
                    fail_timeout = 1'b1;
                end else begin
                    tmr_d = tmr_dec;
                end
            end

            ST_XFER: begin
                if (clk_fe) begin
                    tmr_d = WDT_LOAD;
                    if (bit_cnt_q >= PS2_ACK_FE_CNT) begin
                        ack_bad_d  = data_s;
                        data_low_d = 1'b0;
                        bit_cnt_d  = PS2_BIT_CNT_END;
                        state_d    = ST_WAIT_IDLE;
                    end else begin
                        // Ones shifted in from the top give the stop bit
                        // (released line) on fe#10.
                        data_low_d = ~shift_q[0];
                        shift_d    = {1'b1, shift_q[8:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end else if (tmr_q == '0) begin
                    fail         = 1'b1;
                    fail_timeout = 1'b1;
                end else begin
                    tmr_d = tmr_dec;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_fe) begin
                    tmr_d = WDT_LOAD;
                end else if (tmr_q == '0) begin
                    fail         = 1'b1;
                    fail_timeout = 1'b1;
                end else begin
                    tmr_d = tmr_dec;
                    if (clk_s && data_s) begin
                        if (ack_bad_q) begin
                            fail = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                data_low_d = 1'b0;
            end
        endcase

        if (fail) begin
            data_low_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != RETRY_W'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                tmr_d   = INH_LOAD;
                state_d = ST_INHIBIT;
            end else begin
                ack_err_d = ~fail_timeout;
                timeout_d = fail_timeout;
                state_d   = ST_IDLE;
            end
`else
            ack_err_d = ~fail_timeout;
            timeout_d = fail_timeout;
            state_d   = ST_IDLE;
`endif
        end
    end

    assign tx_ready           = (state_q == ST_IDLE);
    assign busy               = (state_q != ST_IDLE);
    assign ps2_clk_drive_low  = (state_q == ST_INHIBIT);
    assign ps2_data_drive_low = data_low_q;
    assign done               = done_q;
    assign ack_err            = ack_err_q;
    assign timeout_err        = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Scoreboard bench for ps2_host_tx with a PS/2 device model. Scaled
//   parameters (1 MHz system clock) keep transfers short: inhibit = 100
//   cycles, watchdog = 1000 cycles, device clock half-period = 20 cycles.

module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int CLK_HZ     = 1_000_000;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_MS = 1;
    localparam int MAX_RETRY  = 2;
    localparam int INH_CYC    = 100;
    localparam int WDT_CYC    = 1000;
    localparam int H          = 20;

`ifdef PS2_TX_RETRY_EN
    localparam int N_FAIL = MAX_RETRY + 1;
`else
    localparam int N_FAIL = 1;
`endif

    localparam int OUT_DONE = 0, OUT_ACKERR = 1, OUT_TMO = 2;
    localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;

    typedef struct {
        int         mode;
        logic [7:0] b;
    } att_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, clk_dl, data_dl, busy, done, ack_err, timeout_err;
    logic       bfm_clk = 1'b1, bfm_data = 1'b1;
    wire        ps2_clk_line  = ~clk_dl & bfm_clk;
    wire        ps2_data_line = ~data_dl & bfm_data;

    int   tests = 0, fails = 0;
    int   cyc = 0;
    int   rts_cyc = 0;
    logic prev_clk_dl = 1'b0;
    int   bfm_fe_cnt = 0;
    bit   bfm_abort = 1'b0, bfm_busy = 1'b0;
    att_t att_q[$];
    int   out_q[$];

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_MS (TIMEOUT_MS),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .ps2_clk_in         (ps2_clk_line),
        .ps2_data_in        (ps2_data_line),
        .ps2_clk_drive_low  (clk_dl),
        .ps2_data_drive_low (data_dl),
        .busy               (busy),
        .done               (done),
        .ack_err            (ack_err),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // RTS entry: clock released and data pulled low in the same cycle.
    always @(negedge clk) begin
        if (data_dl && !clk_dl && prev_clk_dl) rts_cyc = cyc;
        prev_clk_dl = clk_dl;
    end

    // Outcome monitor: pops the expected outcome whenever a pulse appears.
    initial begin
        int code, exp;
        forever begin
            @(negedge clk);
            if (done || ack_err || timeout_err) begin
                code = done ? OUT_DONE : (ack_err ? OUT_ACKERR : OUT_TMO);
                chk("pulse_exclusive", int'(done) + int'(ack_err) + int'(timeout_err), 1);
                if (out_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_outcome: got code %0d, expected none", code);
                end else begin
                    exp = out_q.pop_front();
                    chk("outcome", code, exp);
                    if (exp == OUT_TMO) chk("timeout_latency", cyc - rts_cyc, WDT_CYC);
                end
                chk("clk_released", clk_dl, 0);
                chk("data_released", data_dl, 0);
                chk("ready_at_end", tx_ready, 1);
                @(negedge clk);
                chk("pulse_width", done | ack_err | timeout_err, 0);
            end
        end
    end

    // PS/2 device model.
    initial begin
        att_t       a;
        int         low_cnt;
        logic [9:0] cap;
        bit         known;
        forever begin
            @(negedge clk);
            while (ps2_clk_line) @(negedge clk);
            bfm_busy   = 1'b1;
            bfm_fe_cnt = 0;
            low_cnt    = 0;
            while (!ps2_clk_line && !bfm_abort) begin
                low_cnt++;
                @(negedge clk);
            end
            if (bfm_abort) begin
                bfm_busy = 1'b0;
                continue;
            end
            chk("inhibit_long_enough", (low_cnt >= INH_CYC) ? 1 : 0, 1);
            chk("rts_data_low", ps2_data_line, 0);
            known = (att_q.size() != 0);
            if (!known) begin
                tests++;
                fails++;
                $display("FAIL unexpected_attempt: got an RTS, expected none");
                a.mode = M_ACK;
                a.b    = 8'h00;
            end else begin
                a = att_q.pop_front();
            end
            if (a.mode == M_SILENT) begin
                bfm_busy = 1'b0;
                continue;
            end
            repeat (10) @(negedge clk);
            cap = '0;
            for (int i = 1; i <= 10 && !bfm_abort; i++) begin
                bfm_clk    = 1'b0;
                bfm_fe_cnt = i;
                repeat (H) @(negedge clk);
                bfm_clk = 1'b1;
                repeat (H / 2) @(negedge clk);
                cap[i-1] = ps2_data_line;
                repeat (H / 2) @(negedge clk);
            end
            if (!bfm_abort) begin
                if (a.mode == M_ACK) bfm_data = 1'b0;
                repeat (5) @(negedge clk);
                bfm_clk    = 1'b0;
                bfm_fe_cnt = 11;
                repeat (H) @(negedge clk);
                if (known) begin
                    chk("dev_byte", cap[7:0], a.b);
                    chk("dev_parity", cap[8], model_parity(a.b));
                    chk("dev_stop", cap[9], 1);
                end
            end
            bfm_clk  = 1'b1;
            bfm_data = 1'b1;
            bfm_busy = 1'b0;
        end
    end

    task automatic plan(input logic [7:0] b, input int mode);
        att_t a;
        a.b = b;
        a.mode = mode;
        if (mode == M_ACK) begin
            att_q.push_back(a);
            out_q.push_back(OUT_DONE);
        end else begin
            for (int i = 0; i < N_FAIL; i++) att_q.push_back(a);
            out_q.push_back(mode == M_NACK ? OUT_ACKERR : OUT_TMO);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_seen", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_drops_after_accept", tx_ready, 0);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic settle(input string name);
        int n = 0;
        while ((out_q.size() != 0 || busy || bfm_busy) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_settled"}, (out_q.size() == 0 && !busy && !bfm_busy) ? 1 : 0, 1);
        chk({name, "_attempts_used"}, att_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int   viol, got, n;
        logic [7:0] rb;
        att_t a;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clk_dl", clk_dl, 0);
        chk("rst_data_dl", data_dl, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_timeout", timeout_err, 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Set-LEDs command, device ACKs.
        plan(PS2_CMD_SET_LEDS, M_ACK);
        send(PS2_CMD_SET_LEDS);
        settle("set_leds");

        // 0x00 with the device leaving ACK high.
        plan(8'h00, M_NACK);
        send(8'h00);
        settle("nack_00");

        // Device never clocks after RTS.
        plan(8'h5A, M_SILENT);
        send(8'h5A);
        settle("timeout");

        // tx_valid held with 0x55 throughout a transfer.
        plan(8'hA3, M_ACK);
        send(8'hA3);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        viol = 0;
        got  = 0;
        n    = 0;
        while (!got && n < 20000) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1;
                tx_valid = 1'b0;
            end else if (tx_ready) begin
                viol++;
            end
        end
        tx_valid = 1'b0;
        chk("hold_saw_done", got, 1);
        chk("hold_no_ready_while_busy", viol, 0);
        settle("hold_first");
        plan(8'h02, M_ACK);
        send(8'h02);
        settle("hold_second");

        // Reset at fe#5.
        a.b = 8'h3C;
        a.mode = M_ACK;
        att_q.push_back(a);
        send(8'h3C);
        n = 0;
        while (bfm_fe_cnt != 5 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_fe5", bfm_fe_cnt, 5);
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_clk_dl", clk_dl, 0);
        chk("midrst_data_dl", data_dl, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        bfm_abort = 1'b1;
        n = 0;
        while (bfm_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("bfm_aborted", bfm_busy, 0);
        bfm_abort = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        plan(8'hC3, M_ACK);
        send(8'hC3);
        settle("after_reset");

        // First attempt NACKed, second ACKed.
        a.b = 8'h96;
        a.mode = M_NACK;
        att_q.push_back(a);
`ifdef PS2_TX_RETRY_EN
        a.mode = M_ACK;
        att_q.push_back(a);
        out_q.push_back(OUT_DONE);
`else
        out_q.push_back(OUT_ACKERR);
`endif
        send(8'h96);
        settle("nack_then_ack");

        // Random bytes with random device response.
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            plan(rb, ($urandom_range(0, 9) < 7) ? M_ACK : M_NACK);
            send(rb);
            settle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
